// File: rtl/fractal_sync_pkg.sv
// fractal_sync_pkg: shared credit-count width helper and error code for the fractal_sync tree
package fractal_sync_pkg;
  localparam logic ERR_CREDIT_OVF = 1'b1;
  function automatic int unsigned cnt_w(int unsigned max_credits);
    return $clog2(max_credits + 1);
  endfunction
endpackage

// File: rtl/fractal_sync_credit_cnt.sv
// fractal_sync_credit_cnt: per-output up/down saturating credit counter with sticky overflow flag
module fractal_sync_credit_cnt
  import fractal_sync_pkg::*;
#(
  parameter int unsigned MAX_CREDITS = 4,
  localparam int unsigned CNT_W = cnt_w(MAX_CREDITS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_i,
  input  logic             ret_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic at_max;
  assign at_max = cnt_o == CNT_W'(MAX_CREDITS);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= CNT_W'(MAX_CREDITS);
      ovf_o <= 1'b0;
    end else begin
      if (issue_i && !ret_i) cnt_o <= cnt_o - CNT_W'(1);
      else if (ret_i && !issue_i && !at_max) cnt_o <= cnt_o + CNT_W'(1);
      if (ret_i && !issue_i && at_max) ovf_o <= ERR_CREDIT_OVF;
    end
  end
endmodule

// File: rtl/fractal_sync_credit_arbiter.sv
// fractal_sync_credit_arbiter: round-robin sharing of credit-controlled output channels among request FIFOs
module fractal_sync_credit_arbiter
  import fractal_sync_pkg::*;
#(
  parameter int unsigned IN_PORTS = 1,
  parameter int unsigned OUT_PORTS = 1,
  parameter int unsigned MAX_CREDITS = 4,
  parameter type fsync_req_t = logic,
  localparam int unsigned CNT_W = cnt_w(MAX_CREDITS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [IN_PORTS-1:0]  empty_i,
  output logic [IN_PORTS-1:0]  pop_o,
  input  fsync_req_t           element_i [IN_PORTS],
  output logic [OUT_PORTS-1:0] valid_o,
  output fsync_req_t           element_o [OUT_PORTS],
  input  logic [OUT_PORTS-1:0] credit_ret_i,
  output logic [CNT_W-1:0]     credit_o [OUT_PORTS],
  output logic                 err_o
);
  localparam int unsigned PTR_W = IN_PORTS > 1 ? $clog2(IN_PORTS) : 1;
  logic [PTR_W-1:0]     rr_q, rr_d, idx;
  logic [PTR_W-1:0]     src [OUT_PORTS];
  logic [IN_PORTS-1:0]  pop_d;
  logic [OUT_PORTS-1:0] gnt, ovf;
  logic                 found;
  int                   k_max, pos;
  // Outputs claim inputs in index order; k_max tracks the furthest scan offset granted
  always_comb begin
    pop_d = '0;
    gnt = '0;
    k_max = 0;
    pos = 0;
    idx = '0;
    found = 1'b0;
    for (int o = 0; o < OUT_PORTS; o++) begin
      src[o] = '0;
      found = 1'b0;
      if (rst_ni && en_i && credit_o[o] != '0)
        for (int k = 0; k < IN_PORTS; k++) begin
          pos = int'(rr_q) + k;
          idx = PTR_W'(pos >= int'(IN_PORTS) ? pos - int'(IN_PORTS) : pos);
          if (!found && !empty_i[idx] && !pop_d[idx]) begin
            found = 1'b1;
            pop_d[idx] = 1'b1;
            gnt[o] = 1'b1;
            src[o] = idx;
            k_max = k > k_max ? k : k_max;
          end
        end
    end
    pos = int'(rr_q) + k_max + 1;
    rr_d = PTR_W'(pos >= int'(IN_PORTS) ? pos - int'(IN_PORTS) : pos);
  end
  assign pop_o = pop_d;
  assign err_o = |ovf;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
      valid_o <= '0;
      for (int o = 0; o < OUT_PORTS; o++) element_o[o] <= fsync_req_t'('0);
    end else begin
      if (|gnt) rr_q <= rr_d;
      valid_o <= gnt;
      for (int o = 0; o < OUT_PORTS; o++) element_o[o] <= gnt[o] ? element_i[src[o]] : fsync_req_t'('0);
    end
  end
  for (genvar g = 0; g < OUT_PORTS; g++) begin : g_cnt
    fractal_sync_credit_cnt #(.MAX_CREDITS(MAX_CREDITS)) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .issue_i (gnt[g]),
      .ret_i   (credit_ret_i[g]),
      .cnt_o   (credit_o[g]),
      .ovf_o   (ovf[g])
    );
  end
endmodule

// File: tb/tb_fractal_sync_credit_arbiter.sv
// tb_fractal_sync_credit_arbiter: directed checks of allocation, credits, enable and reset
module tb_fractal_sync_credit_arbiter;
  logic       clk = 1'b0;
  logic       rst_n, en1, en2, err1, err2;
  logic [3:0] empty1, pop1, empty2, pop2;
  logic [7:0] el1 [4];
  logic [7:0] elo1 [1];
  logic [7:0] el2 [4];
  logic [7:0] elo2 [2];
  logic [0:0] valid1, ret1;
  logic [1:0] valid2, ret2;
  logic [1:0] cr1 [1];
  logic [2:0] cr2 [2];
  int errors = 0, checks = 0;
  int cnt [4];
  int served [4];
  logic [7:0] exp_el;

  always #5 clk = ~clk;

  fractal_sync_credit_arbiter #(.IN_PORTS(4), .OUT_PORTS(1), .MAX_CREDITS(2), .fsync_req_t(logic [7:0])) u1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en1), .empty_i(empty1), .pop_o(pop1), .element_i(el1),
    .valid_o(valid1), .element_o(elo1), .credit_ret_i(ret1), .credit_o(cr1), .err_o(err1));

  fractal_sync_credit_arbiter #(.IN_PORTS(4), .OUT_PORTS(2), .MAX_CREDITS(4), .fsync_req_t(logic [7:0])) u2 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .empty_i(empty2), .pop_o(pop2), .element_i(el2),
    .valid_o(valid2), .element_o(elo2), .credit_ret_i(ret2), .credit_o(cr2), .err_o(err2));

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      empty1[i] = cnt[i] == 0;
      el1[i] = 8'(i * 16 + served[i]);
    end
  endtask

  task automatic set_fifos(input int n);
    for (int i = 0; i < 4; i++) cnt[i] = n;
    apply();
  endtask

  // FIFO model follows the pops seen just before each rising edge
  task automatic tick();
    logic [3:0] p;
    p = pop1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (p[i]) begin
        cnt[i]--;
        served[i]++;
      end
    apply();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en1 = 1'b1; en2 = 1'b1; ret1 = '0; ret2 = '0; empty2 = '1;
    for (int i = 0; i < 4; i++) begin served[i] = 0; el2[i] = '0; end
    set_fifos(2);
    tick();
    tick();
    checks++; if (pop1 !== 4'b0000) begin errors++; $display("FAIL reset_pop got=%b exp=0000", pop1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid1); end
    checks++; if (elo1[0] !== 8'h00) begin errors++; $display("FAIL reset_elem got=%h exp=00", elo1[0]); end
    checks++; if (cr1[0] !== 2'd2) begin errors++; $display("FAIL reset_credit got=%0d exp=2", cr1[0]); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err1); end
    checks++; if (cr2[0] !== 3'd4 || cr2[1] !== 3'd4) begin errors++; $display("FAIL reset_credit2 got=%0d,%0d exp=4,4", cr2[0], cr2[1]); end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b1; ret1 = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      exp_el = 8'((c % 4) * 16 + c / 4);
      checks++; if (pop1 !== 4'(1 << (c % 4))) begin errors++; $display("FAIL rr_pop c=%0d got=%b exp=%b", c, pop1, 4'(1 << (c % 4))); end
      tick();
      checks++; if (valid1 !== 1'b1 || elo1[0] !== exp_el) begin errors++; $display("FAIL rr_out c=%0d got=%b/%h exp=1/%h", c, valid1, elo1[0], exp_el); end
      checks++; if (cr1[0] !== 2'd2) begin errors++; $display("FAIL rr_credit c=%0d got=%0d exp=2", c, cr1[0]); end
    end
    ret1 = 1'b0;
    #1;
    checks++; if (pop1 !== 4'b0000) begin errors++; $display("FAIL rr_drained_pop got=%b exp=0000", pop1); end
    tick();
    checks++; if (valid1 !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL rr_idle got=valid %b err %b exp=0 0", valid1, err1); end
  endtask

  task automatic test_no_double_grant();
    empty2 = 4'b0101; el2[0] = 8'hEE; el2[1] = 8'h11; el2[2] = 8'hEE; el2[3] = 8'h33;
    #1;
    checks++; if (pop2 !== 4'b1010) begin errors++; $display("FAIL dual_pop got=%b exp=1010", pop2); end
    tick();
    checks++; if (valid2 !== 2'b11 || elo2[0] !== 8'h11 || elo2[1] !== 8'h33) begin errors++; $display("FAIL dual_out got=%b %h %h exp=11 11 33", valid2, elo2[0], elo2[1]); end
    checks++; if (cr2[0] !== 3'd3 || cr2[1] !== 3'd3) begin errors++; $display("FAIL dual_credit got=%0d,%0d exp=3,3", cr2[0], cr2[1]); end
    empty2 = 4'b0000;
    for (int i = 0; i < 4; i++) el2[i] = 8'(8'hA0 + i);
    #1;
    checks++; if (pop2 !== 4'b0011) begin errors++; $display("FAIL dual_rr_pop got=%b exp=0011", pop2); end
    tick();
    checks++; if (elo2[0] !== 8'hA0 || elo2[1] !== 8'hA1) begin errors++; $display("FAIL dual_rr_out got=%h %h exp=a0 a1", elo2[0], elo2[1]); end
    empty2 = 4'b1111;
    #1;
    tick();
    checks++; if (valid2 !== 2'b00) begin errors++; $display("FAIL dual_idle got=%b exp=00", valid2); end
  endtask

  task automatic test_credits();
    set_fifos(2);
    #1;
    checks++; if (pop1 !== 4'b0001) begin errors++; $display("FAIL cr_pop0 got=%b exp=0001", pop1); end
    tick();
    checks++; if (cr1[0] !== 2'd1 || elo1[0] !== 8'h02) begin errors++; $display("FAIL cr_one got=%0d %h exp=1 02", cr1[0], elo1[0]); end
    checks++; if (pop1 !== 4'b0010) begin errors++; $display("FAIL cr_pop1 got=%b exp=0010", pop1); end
    tick();
    checks++; if (cr1[0] !== 2'd0 || pop1 !== 4'b0000) begin errors++; $display("FAIL cr_empty got=%0d %b exp=0 0000", cr1[0], pop1); end
    tick();
    checks++; if (valid1 !== 1'b0 || pop1 !== 4'b0000) begin errors++; $display("FAIL cr_stall got=%b %b exp=0 0000", valid1, pop1); end
    ret1 = 1'b1;
    #1;
    tick();
    ret1 = 1'b0;
    #1;
    checks++; if (cr1[0] !== 2'd1 || pop1 !== 4'b0100) begin errors++; $display("FAIL cr_return got=%0d %b exp=1 0100", cr1[0], pop1); end
    tick();
    checks++; if (valid1 !== 1'b1 || elo1[0] !== 8'h22 || cr1[0] !== 2'd0) begin errors++; $display("FAIL cr_reissue got=%b %h %0d exp=1 22 0", valid1, elo1[0], cr1[0]); end
    checks++; if (pop1 !== 4'b0000) begin errors++; $display("FAIL cr_stall2 got=%b exp=0000", pop1); end
  endtask

  task automatic test_credit_edge();
    ret1 = 1'b1;
    #1;
    tick();
    checks++; if (cr1[0] !== 2'd1 || pop1 !== 4'b1000) begin errors++; $display("FAIL edge_pre got=%0d %b exp=1 1000", cr1[0], pop1); end
    tick();
    checks++; if (cr1[0] !== 2'd1 || elo1[0] !== 8'h32) begin errors++; $display("FAIL edge_same got=%0d %h exp=1 32", cr1[0], elo1[0]); end
    set_fifos(0);
    #1;
    tick();
    checks++; if (cr1[0] !== 2'd2 || err1 !== 1'b0) begin errors++; $display("FAIL edge_full got=%0d %b exp=2 0", cr1[0], err1); end
    tick();
    checks++; if (cr1[0] !== 2'd2 || err1 !== 1'b1) begin errors++; $display("FAIL edge_ovf got=%0d %b exp=2 1", cr1[0], err1); end
    ret1 = 1'b0;
    tick();
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL edge_sticky got=%b exp=1", err1); end
  endtask

  task automatic test_enable();
    set_fifos(2);
    #1;
    exp_el = 8'(served[0]);
    checks++; if (pop1 !== 4'b0001) begin errors++; $display("FAIL en_pop got=%b exp=0001", pop1); end
    tick();
    en1 = 1'b0;
    #1;
    checks++; if (valid1 !== 1'b1 || elo1[0] !== exp_el) begin errors++; $display("FAIL en_inflight got=%b %h exp=1 %h", valid1, elo1[0], exp_el); end
    checks++; if (pop1 !== 4'b0000 || cr1[0] !== 2'd1) begin errors++; $display("FAIL en_frozen got=%b %0d exp=0000 1", pop1, cr1[0]); end
    ret1 = 1'b1;
    tick();
    ret1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (valid1 !== 1'b0 || pop1 !== 4'b0000) begin errors++; $display("FAIL en_hold c=%0d got=%b %b exp=0 0000", c, valid1, pop1); end
      if (c < 2) tick();
    end
    checks++; if (cr1[0] !== 2'd2) begin errors++; $display("FAIL en_ret got=%0d exp=2", cr1[0]); end
    en1 = 1'b1;
  endtask

  task automatic test_reset_mid();
    #1;
    exp_el = 8'(16 + served[1]);
    checks++; if (pop1 !== 4'b0010) begin errors++; $display("FAIL rst_pre_pop got=%b exp=0010", pop1); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (pop1 !== 4'b0000) begin errors++; $display("FAIL rst_pop got=%b exp=0000", pop1); end
    checks++; if (valid1 !== 1'b1 || elo1[0] !== exp_el) begin errors++; $display("FAIL rst_pre_out got=%b %h exp=1 %h", valid1, elo1[0], exp_el); end
    tick();
    checks++; if (valid1 !== 1'b0 || elo1[0] !== 8'h00 || cr1[0] !== 2'd2 || err1 !== 1'b0) begin errors++; $display("FAIL rst_state got=%b %h %0d %b exp=0 00 2 0", valid1, elo1[0], cr1[0], err1); end
    rst_n = 1'b1;
    #1;
    exp_el = 8'(served[0]);
    checks++; if (pop1 !== 4'b0001) begin errors++; $display("FAIL rst_resume_pop got=%b exp=0001", pop1); end
    tick();
    checks++; if (valid1 !== 1'b1 || elo1[0] !== exp_el || cr1[0] !== 2'd1) begin errors++; $display("FAIL rst_resume got=%b %h %0d exp=1 %h 1", valid1, elo1[0], cr1[0], exp_el); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_no_double_grant();
    test_credits();
    test_credit_edge();
    test_enable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
